// File: rtl/pipeline_pkg.sv
// pipeline_pkg: shared fetch-stage constants and stage-state encoding
package pipeline_pkg;
  localparam int PC_W = 32;
  localparam logic [1:0] ST_RUN = 2'd0;
  localparam logic [1:0] ST_HOLD = 2'd1;
  localparam logic [1:0] ST_FLUSH = 2'd2;
  localparam logic [31:0] NOP_DEFAULT = 32'h0000_0000;
endpackage

// File: rtl/pc_ifid_stage_if.sv
// pc_ifid_stage_if: hazard/redirect inputs and fetch/IF-ID outputs of the fetch stage
interface pc_ifid_stage_if #(parameter int CNT_W = 16);
  logic pcEnable;
  logic ifEnable;
  logic redirect;
  logic [31:0] redirectPc;
  logic [31:0] instrIn;
  logic [31:0] pcOut;
  logic [31:0] ifidInstr;
  logic [31:0] ifidPcPlus4;
  logic ifidValid;
  logic [1:0] stageState;
  logic [CNT_W-1:0] stallCount;
  logic stallTimeout;
  modport master (
    output pcEnable, ifEnable, redirect, redirectPc, instrIn,
    input pcOut, ifidInstr, ifidPcPlus4, ifidValid, stageState, stallCount, stallTimeout
  );
  modport slave (
    input pcEnable, ifEnable, redirect, redirectPc, instrIn,
    output pcOut, ifidInstr, ifidPcPlus4, ifidValid, stageState, stallCount, stallTimeout
  );
endinterface

// File: rtl/pc_ifid_stage_stall_watchdog.sv
// stall_watchdog: saturating stall statistics and sticky consecutive-stall timeout
module stall_watchdog #(
  parameter int CNT_W = 16,
  parameter int WDOG_LIMIT = 64
) (
  input  logic clk,
  input  logic reset,
  input  logic stall,
  input  logic clear,
  output logic [CNT_W-1:0] stallCount,
  output logic stallTimeout
);
  localparam int WW = $clog2(WDOG_LIMIT + 1);
  logic [WW-1:0] consec;
  // clear wins over stall; both counters saturate, timeout latches until reset
  always_ff @(posedge clk) begin
    if (reset) begin
      stallCount <= '0;
      consec <= '0;
      stallTimeout <= 1'b0;
    end else if (clear) begin
      consec <= '0;
    end else if (stall) begin
      stallCount <= &stallCount ? stallCount : stallCount + 1'b1;
      consec <= consec == WW'(WDOG_LIMIT) ? consec : consec + 1'b1;
      stallTimeout <= stallTimeout | (consec >= WW'(WDOG_LIMIT - 1));
    end
  end
endmodule

// File: rtl/pc_ifid_stage.sv
// pc_ifid_stage: PC and IF/ID register sequencing advance, hold and flush cycles
module pc_ifid_stage import pipeline_pkg::*; #(
  parameter logic [PC_W-1:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = NOP_DEFAULT,
  parameter int CNT_W = 16,
  parameter int WDOG_LIMIT = 64
) (
  input logic clk,
  input logic reset,
  pc_ifid_stage_if.slave bus
);
  logic stall;
  logic [PC_W-1:0] pcNext;
  assign stall = !bus.redirect && !(bus.pcEnable && bus.ifEnable);
  assign pcNext = bus.pcOut + 32'd4;
  stall_watchdog #(.CNT_W(CNT_W), .WDOG_LIMIT(WDOG_LIMIT)) watchdog (
    .clk(clk),
    .reset(reset),
    .stall(stall),
    .clear(!stall),
    .stallCount(bus.stallCount),
    .stallTimeout(bus.stallTimeout)
  );
  // redirect beats stall beats advance; a mismatched enable pair stalls both registers
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.pcOut <= RESET_PC;
      bus.ifidInstr <= NOP_INSTR;
      bus.ifidPcPlus4 <= RESET_PC + 32'd4;
      bus.ifidValid <= 1'b0;
      bus.stageState <= ST_RUN;
    end else if (bus.redirect) begin
      bus.pcOut <= {bus.redirectPc[31:2], 2'b00};
      bus.ifidInstr <= NOP_INSTR;
      bus.ifidValid <= 1'b0;
      bus.stageState <= ST_FLUSH;
    end else if (stall) begin
      bus.stageState <= ST_HOLD;
    end else begin
      bus.pcOut <= pcNext;
      bus.ifidInstr <= bus.instrIn;
      bus.ifidPcPlus4 <= pcNext;
      bus.ifidValid <= 1'b1;
      bus.stageState <= ST_RUN;
    end
  end
endmodule

// File: tb/tb_pc_ifid_stage.sv
// tb_pc_ifid_stage: directed and randomized checks of the fetch stage against a behavioural model
module tb_pc_ifid_stage;
  localparam int CW = 4;
  localparam int LIM = 4;
  localparam int CMAX = (1 << CW) - 1;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int checks = 0;
  int errors = 0;
  logic [31:0] mPc, mInstr, mPp4;
  logic mValid, mTo;
  logic [1:0] mState;
  int mCnt, mConsec;
  pc_ifid_stage_if #(.CNT_W(CW)) m ();
  pc_ifid_stage_if #(.CNT_W(CW)) w ();
  assign w.pcEnable = m.pcEnable;
  assign w.ifEnable = m.ifEnable;
  assign w.redirect = m.redirect;
  assign w.redirectPc = m.redirectPc;
  assign w.instrIn = m.instrIn;
  pc_ifid_stage #(.CNT_W(CW), .WDOG_LIMIT(LIM)) dut (.clk(clk), .reset(reset), .bus(m));
  pc_ifid_stage #(.RESET_PC(32'hFFFF_FFF8), .CNT_W(CW), .WDOG_LIMIT(LIM)) dutWrap (.clk(clk), .reset(reset), .bus(w));
  always #5 clk = ~clk;

  task automatic doReset();
    reset = 1'b1;
    m.pcEnable = 1'b1; m.ifEnable = 1'b1; m.redirect = 1'b0; m.redirectPc = '0; m.instrIn = '0;
    @(posedge clk);
    @(posedge clk);
    mPc = 32'h0; mInstr = 32'h0; mPp4 = 32'h4; mValid = 1'b0; mState = 2'd0;
    mCnt = 0; mConsec = 0; mTo = 1'b0;
    #1 reset = 1'b0;
  endtask

  task automatic tick(input logic pe, input logic ie, input logic rd, input logic [31:0] rpc, input logic [31:0] ins);
    m.pcEnable = pe; m.ifEnable = ie; m.redirect = rd; m.redirectPc = rpc; m.instrIn = ins;
    @(posedge clk);
    if (rd) begin
      mPc = rpc & ~32'h3; mInstr = 32'h0; mValid = 1'b0; mState = 2'd2; mConsec = 0;
    end else if (!(pe && ie)) begin
      mCnt = (mCnt + 1 > CMAX) ? CMAX : mCnt + 1;
      mConsec = (mConsec + 1 > LIM) ? LIM : mConsec + 1;
      if (mConsec == LIM) mTo = 1'b1;
      mState = 2'd1;
    end else begin
      mPp4 = mPc + 4; mPc = mPc + 4; mInstr = ins; mValid = 1'b1; mState = 2'd0; mConsec = 0;
    end
    #1;
  endtask

  task automatic test_reset();
    doReset();
    checks += 8;
    if (m.pcOut !== 32'h0) begin errors++; $display("FAIL reset_pc got %h exp 0", m.pcOut); end
    if (m.ifidInstr !== 32'h0) begin errors++; $display("FAIL reset_instr got %h exp 0", m.ifidInstr); end
    if (m.ifidPcPlus4 !== 32'h4) begin errors++; $display("FAIL reset_pp4 got %h exp 4", m.ifidPcPlus4); end
    if (m.ifidValid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", m.ifidValid); end
    if (m.stageState !== 2'd0) begin errors++; $display("FAIL reset_state got %0d exp 0", m.stageState); end
    if (m.stallCount !== 4'd0) begin errors++; $display("FAIL reset_cnt got %0d exp 0", m.stallCount); end
    if (m.stallTimeout !== 1'b0) begin errors++; $display("FAIL reset_to got %b exp 0", m.stallTimeout); end
    if (w.pcOut !== 32'hFFFF_FFF8) begin errors++; $display("FAIL reset_wrap_pc got %h exp fffffff8", w.pcOut); end
  endtask

  task automatic test_run();
    logic [31:0] ins [3];
    logic [31:0] wrapPc [3];
    ins = '{32'h8C01_0004, 32'h0022_1820, 32'hAC03_0008};
    wrapPc = '{32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004};
    for (int i = 0; i < 3; i++) begin
      tick(1, 1, 0, 0, ins[i]);
      checks += 5;
      if (m.pcOut !== 32'(4 * (i + 1))) begin errors++; $display("FAIL run_pc%0d got %h exp %h", i, m.pcOut, 4 * (i + 1)); end
      if (m.ifidInstr !== ins[i]) begin errors++; $display("FAIL run_instr%0d got %h exp %h", i, m.ifidInstr, ins[i]); end
      if (m.ifidPcPlus4 !== 32'(4 * (i + 1))) begin errors++; $display("FAIL run_pp4%0d got %h exp %h", i, m.ifidPcPlus4, 4 * (i + 1)); end
      if (m.ifidValid !== 1'b1) begin errors++; $display("FAIL run_valid%0d got %b exp 1", i, m.ifidValid); end
      if (w.pcOut !== wrapPc[i]) begin errors++; $display("FAIL wrap_pc%0d got %h exp %h", i, w.pcOut, wrapPc[i]); end
    end
  endtask

  task automatic test_stall();
    for (int i = 0; i < 2; i++) begin
      tick(0, 0, 0, 0, 32'hDEAD_BEEF);
      checks += 4;
      if (m.pcOut !== 32'hC) begin errors++; $display("FAIL stall_pc%0d got %h exp c", i, m.pcOut); end
      if (m.ifidInstr !== 32'hAC03_0008) begin errors++; $display("FAIL stall_instr%0d got %h exp ac030008", i, m.ifidInstr); end
      if (m.stageState !== 2'd1) begin errors++; $display("FAIL stall_state%0d got %0d exp 1", i, m.stageState); end
      if (m.stallCount !== 4'(i + 1)) begin errors++; $display("FAIL stall_cnt%0d got %0d exp %0d", i, m.stallCount, i + 1); end
    end
    tick(1, 1, 0, 0, 32'h1111_1111);
    checks += 3;
    if (m.pcOut !== 32'h10) begin errors++; $display("FAIL resume_pc got %h exp 10", m.pcOut); end
    if (m.ifidInstr !== 32'h1111_1111) begin errors++; $display("FAIL resume_instr got %h exp 11111111", m.ifidInstr); end
    if (m.stageState !== 2'd0) begin errors++; $display("FAIL resume_state got %0d exp 0", m.stageState); end
  endtask

  task automatic test_redirect_in_stall();
    tick(0, 0, 0, 0, 32'h0);
    tick(0, 0, 1, 32'h0000_0043, 32'h3333_3333);
    checks += 6;
    if (m.pcOut !== 32'h40) begin errors++; $display("FAIL flush_pc got %h exp 40", m.pcOut); end
    if (m.ifidInstr !== 32'h0) begin errors++; $display("FAIL flush_instr got %h exp 0", m.ifidInstr); end
    if (m.ifidValid !== 1'b0) begin errors++; $display("FAIL flush_valid got %b exp 0", m.ifidValid); end
    if (m.stageState !== 2'd2) begin errors++; $display("FAIL flush_state got %0d exp 2", m.stageState); end
    if (m.ifidPcPlus4 !== 32'h10) begin errors++; $display("FAIL flush_pp4 got %h exp 10", m.ifidPcPlus4); end
    if (m.stallCount !== 4'd3) begin errors++; $display("FAIL flush_cnt got %0d exp 3", m.stallCount); end
    tick(1, 1, 0, 0, 32'h2222_2222);
    checks += 4;
    if (m.ifidValid !== 1'b1) begin errors++; $display("FAIL target_valid got %b exp 1", m.ifidValid); end
    if (m.ifidInstr !== 32'h2222_2222) begin errors++; $display("FAIL target_instr got %h exp 22222222", m.ifidInstr); end
    if (m.ifidPcPlus4 !== 32'h44) begin errors++; $display("FAIL target_pp4 got %h exp 44", m.ifidPcPlus4); end
    if (m.pcOut !== 32'h44) begin errors++; $display("FAIL target_pc got %h exp 44", m.pcOut); end
  endtask

  task automatic test_mismatch();
    tick(1, 0, 0, 0, 32'h4444_4444);
    checks += 3;
    if (m.pcOut !== 32'h44) begin errors++; $display("FAIL mis_pc got %h exp 44", m.pcOut); end
    if (m.ifidInstr !== 32'h2222_2222) begin errors++; $display("FAIL mis_instr got %h exp 22222222", m.ifidInstr); end
    if (m.stageState !== 2'd1) begin errors++; $display("FAIL mis_state got %0d exp 1", m.stageState); end
    tick(0, 1, 0, 0, 32'h5555_5555);
    checks += 2;
    if (m.pcOut !== 32'h44) begin errors++; $display("FAIL mis2_pc got %h exp 44", m.pcOut); end
    if (m.stallCount !== 4'd5) begin errors++; $display("FAIL mis2_cnt got %0d exp 5", m.stallCount); end
  endtask

  task automatic test_watchdog();
    tick(1, 1, 0, 0, 32'h0);
    for (int i = 0; i < 3; i++) tick(0, 0, 0, 0, 32'h0);
    tick(0, 0, 1, 32'h100, 32'h0);
    for (int i = 0; i < 3; i++) tick(0, 0, 0, 0, 32'h0);
    checks++;
    if (m.stallTimeout !== 1'b0) begin errors++; $display("FAIL wdog_cleared got %b exp 0", m.stallTimeout); end
    tick(0, 0, 0, 0, 32'h0);
    checks++;
    if (m.stallTimeout !== 1'b1) begin errors++; $display("FAIL wdog_fire got %b exp 1", m.stallTimeout); end
    tick(1, 1, 0, 0, 32'h0);
    tick(0, 0, 1, 32'h200, 32'h0);
    checks++;
    if (m.stallTimeout !== 1'b1) begin errors++; $display("FAIL wdog_sticky got %b exp 1", m.stallTimeout); end
    for (int i = 0; i < 5; i++) tick(0, 0, 0, 0, 32'h0);
    checks++;
    if (m.stallCount !== 4'd15) begin errors++; $display("FAIL cnt_sat got %0d exp 15", m.stallCount); end
    doReset();
    checks += 2;
    if (m.stallTimeout !== 1'b0) begin errors++; $display("FAIL wdog_reset got %b exp 0", m.stallTimeout); end
    if (m.stallCount !== 4'd0) begin errors++; $display("FAIL cnt_reset got %0d exp 0", m.stallCount); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] a;
    for (int i = 0; i < 3; i++) begin
      a = $urandom;
      tick(1, 1, 1, a, $urandom);
      checks += 3;
      if (m.pcOut !== {a[31:2], 2'b00}) begin errors++; $display("FAIL b2b_pc%0d got %h exp %h", i, m.pcOut, {a[31:2], 2'b00}); end
      if (m.ifidValid !== 1'b0) begin errors++; $display("FAIL b2b_valid%0d got %b exp 0", i, m.ifidValid); end
      if (m.stageState !== 2'd2) begin errors++; $display("FAIL b2b_state%0d got %0d exp 2", i, m.stageState); end
    end
  endtask

  task automatic test_random();
    int stallBias;
    for (int i = 0; i < 400; i++) begin
      if (i % 50 == 0) stallBias = $urandom_range(10, 60);
      tick($urandom_range(0, 99) >= stallBias, $urandom_range(0, 99) >= stallBias / 2,
           $urandom_range(0, 99) < 8, $urandom, $urandom);
      checks++;
      if (m.pcOut !== mPc || m.ifidInstr !== mInstr || m.ifidPcPlus4 !== mPp4 || m.ifidValid !== mValid ||
          m.stageState !== mState || m.stallCount !== 4'(mCnt) || m.stallTimeout !== mTo) begin
        errors++;
        $display("FAIL rand%0d got pc=%h in=%h p4=%h v=%b st=%0d c=%0d to=%b exp pc=%h in=%h p4=%h v=%b st=%0d c=%0d to=%b",
                 i, m.pcOut, m.ifidInstr, m.ifidPcPlus4, m.ifidValid, m.stageState, m.stallCount, m.stallTimeout,
                 mPc, mInstr, mPp4, mValid, mState, mCnt, mTo);
      end
      if (i == 200) doReset();
    end
  endtask

  initial begin
    test_reset();
    test_run();
    test_stall();
    test_redirect_in_stall();
    test_mismatch();
    test_watchdog();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
